// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter sharing a single-port word RAM with one-cycle registered read
// One pending slot per port, round-robin or fixed-priority grant, read data routed back to the issuing port.
module mem_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_addr,
  input  logic        a_rstrb,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_wmask,
  output logic [31:0] a_rdata,
  output logic        a_busy,
  input  logic [31:0] b_addr,
  input  logic        b_rstrb,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_wmask,
  output logic [31:0] b_rdata,
  output logic        b_busy,
  output logic [31:0] m_addr,
  output logic        m_rstrb,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  input  logic [31:0] m_rdata
);

  typedef enum logic {IDLE, RDATA} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic        a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic [31:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [31:0] a_wdata_q, a_wdata_d, b_wdata_q, b_wdata_d;
  logic [3:0]  a_wmask_q, a_wmask_d, b_wmask_q, b_wmask_d;
  logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic        a_win, b_win;

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    a_vld_d   = a_vld_q;
    a_rd_d    = a_rd_q;
    a_addr_d  = a_addr_q;
    a_wdata_d = a_wdata_q;
    a_wmask_d = a_wmask_q;
    b_vld_d   = b_vld_q;
    b_rd_d    = b_rd_q;
    b_addr_d  = b_addr_q;
    b_wdata_d = b_wdata_q;
    b_wmask_d = b_wmask_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    m_addr    = 32'h0;
    m_rstrb   = 1'b0;
    m_wdata   = 32'h0;
    m_wmask   = 4'h0;

    a_busy = a_vld_q | ((state_q == RDATA) & ~owner_q);
    b_busy = b_vld_q | ((state_q == RDATA) & owner_q);

    // last_q = 1 means B was granted last, so A takes the next tie
    a_win = a_vld_q & (~b_vld_q | FIXED_PRIORITY | last_q);
    b_win = b_vld_q & ~a_win;

    if (state_q == IDLE) begin
      if (a_win) begin
        m_addr  = a_addr_q;
        m_wdata = a_wdata_q;
        a_vld_d = 1'b0;
        last_d  = 1'b0;
        if (a_rd_q) begin
          m_rstrb = 1'b1;
          owner_d = 1'b0;
          state_d = RDATA;
        end else begin
          m_wmask = a_wmask_q;
        end
      end else if (b_win) begin
        m_addr  = b_addr_q;
        m_wdata = b_wdata_q;
        b_vld_d = 1'b0;
        last_d  = 1'b1;
        if (b_rd_q) begin
          m_rstrb = 1'b1;
          owner_d = 1'b1;
          state_d = RDATA;
        end else begin
          m_wmask = b_wmask_q;
        end
      end
    end else begin
      if (owner_q) b_rdata_d = m_rdata;
      else         a_rdata_d = m_rdata;
      state_d = IDLE;
    end

    if (!a_busy && (a_rstrb || (a_wmask != 4'h0))) begin
      a_vld_d   = 1'b1;
      a_rd_d    = (a_wmask == 4'h0);
      a_addr_d  = a_addr;
      a_wdata_d = a_wdata;
      a_wmask_d = a_wmask;
    end
    if (!b_busy && (b_rstrb || (b_wmask != 4'h0))) begin
      b_vld_d   = 1'b1;
      b_rd_d    = (b_wmask == 4'h0);
      b_addr_d  = b_addr;
      b_wdata_d = b_wdata;
      b_wmask_d = b_wmask;
    end

    // A pending write must never reach the RAM during a reset cycle
    if (reset) begin
      m_wmask = 4'h0;
      m_rstrb = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      a_vld_q   <= 1'b0;
      a_rd_q    <= 1'b0;
      a_addr_q  <= 32'h0;
      a_wdata_q <= 32'h0;
      a_wmask_q <= 4'h0;
      b_vld_q   <= 1'b0;
      b_rd_q    <= 1'b0;
      b_addr_q  <= 32'h0;
      b_wdata_q <= 32'h0;
      b_wmask_q <= 4'h0;
      a_rdata_q <= 32'h0;
      b_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      a_vld_q   <= a_vld_d;
      a_rd_q    <= a_rd_d;
      a_addr_q  <= a_addr_d;
      a_wdata_q <= a_wdata_d;
      a_wmask_q <= a_wmask_d;
      b_vld_q   <= b_vld_d;
      b_rd_q    <= b_rd_d;
      b_addr_q  <= b_addr_d;
      b_wdata_q <= b_wdata_d;
      b_wmask_q <= b_wmask_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// A round-robin and a fixed-priority instance share the stimulus and a word RAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_rstrb, b_rstrb;
  logic [3:0]  a_wmask, b_wmask;
  logic [31:0] a_rdata, b_rdata, m_addr, m_wdata, m_rdata;
  logic        a_busy, b_busy, m_rstrb;
  logic [3:0]  m_wmask;
  logic [31:0] f_a_rdata, f_b_rdata, f_m_addr, f_m_wdata, f_m_rdata;
  logic        f_a_busy, f_b_busy, f_m_rstrb;
  logic [3:0]  f_m_wmask;

  logic [31:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          viol = 0;
  int          rd_issues = 0;
  logic [31:0] issue_log [$];

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset),
    .a_addr(a_addr), .a_rstrb(a_rstrb), .a_wdata(a_wdata), .a_wmask(a_wmask),
    .a_rdata(a_rdata), .a_busy(a_busy),
    .b_addr(b_addr), .b_rstrb(b_rstrb), .b_wdata(b_wdata), .b_wmask(b_wmask),
    .b_rdata(b_rdata), .b_busy(b_busy),
    .m_addr(m_addr), .m_rstrb(m_rstrb), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rdata(m_rdata)
  );

  mem_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .a_addr(a_addr), .a_rstrb(a_rstrb), .a_wdata(a_wdata), .a_wmask(a_wmask),
    .a_rdata(f_a_rdata), .a_busy(f_a_busy),
    .b_addr(b_addr), .b_rstrb(b_rstrb), .b_wdata(b_wdata), .b_wmask(b_wmask),
    .b_rdata(f_b_rdata), .b_busy(f_b_busy),
    .m_addr(f_m_addr), .m_rstrb(f_m_rstrb), .m_wdata(f_m_wdata), .m_wmask(f_m_wmask),
    .m_rdata(f_m_rdata)
  );

  // Word RAM: only the round-robin instance may write it
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (m_wmask[i]) mem[m_addr[9:2]][8*i +: 8] = m_wdata[8*i +: 8];
    if (m_rstrb)   m_rdata   <= mem[m_addr[9:2]];
    if (f_m_rstrb) f_m_rdata <= mem[f_m_addr[9:2]];
  end

  always @(posedge clk) begin
    if (!reset) begin
      if ((a_rstrb || a_wmask != 4'h0) && a_busy) viol++;
      if ((b_rstrb || b_wmask != 4'h0) && b_busy) viol++;
    end
    if (m_rstrb) rd_issues++;
    if (m_rstrb || m_wmask != 4'h0) issue_log.push_back(m_addr);
  end

  task automatic idle_inputs;
    a_addr = 32'h0; a_rstrb = 1'b0; a_wdata = 32'h0; a_wmask = 4'h0;
    b_addr = 32'h0; b_rstrb = 1'b0; b_wdata = 32'h0; b_wmask = 4'h0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_addr = 32'h10; a_rstrb = 1'b1;
    b_addr = 32'h30; b_wdata = 32'hFFFF_FFFF; b_wmask = 4'hF;
    @(negedge clk);
    reset = 1'b0; idle_inputs();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy: got %b expected 0", a_busy); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy: got %b expected 0", b_busy); end
    checks++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", a_rdata, b_rdata); end
    checks++; if (m_rstrb !== 1'b0 || m_wmask !== 4'h0) begin errors++; $display("FAIL reset_m: got rstrb %b wmask %b expected 0/0000", m_rstrb, m_wmask); end
    // pending B write must be suppressed when reset arrives in its issue cycle
    b_addr = 32'h34; b_wdata = 32'hFFFF_FFFF; b_wmask = 4'hF;
    @(negedge clk);
    idle_inputs(); reset = 1'b1; #1;
    checks++; if (m_wmask !== 4'h0) begin errors++; $display("FAIL reset_wmask_forced: got %b expected 0000", m_wmask); end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem[13] !== 32'h1234_5678) begin errors++; $display("FAIL reset_no_write: got %h expected 12345678", mem[13]); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_pending_dropped: got %b expected 0", b_busy); end
  endtask

  task automatic test_single_read;
    do_reset();
    a_addr = 32'h10; a_rstrb = 1'b1;
    @(negedge clk); idle_inputs();
    checks++; if (m_rstrb !== 1'b1 || m_addr !== 32'h10) begin errors++; $display("FAIL read_c1_issue: got rstrb %b addr %h expected 1/00000010", m_rstrb, m_addr); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL read_c1_busy: got %b expected 1", a_busy); end
    @(negedge clk);
    checks++; if (m_rstrb !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL read_c2: got rstrb %b busy %b expected 0/1", m_rstrb, a_busy); end
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL read_c3_busy: got %b expected 0", a_busy); end
    checks++; if (a_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_c3_rdata: got %h expected deadbeef", a_rdata); end
  endtask

  task automatic test_byte_write;
    do_reset();
    b_addr = 32'h21; b_wdata = 32'h0000_AA00; b_wmask = 4'b0010;
    @(negedge clk); idle_inputs();
    checks++; if (m_wmask !== 4'b0010 || m_addr !== 32'h21 || m_wdata !== 32'h0000_AA00) begin errors++; $display("FAIL wr_c1_issue: got mask %b addr %h data %h expected 0010/00000021/0000aa00", m_wmask, m_addr, m_wdata); end
    checks++; if (m_rstrb !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL wr_c1_busy: got rstrb %b busy %b expected 0/1", m_rstrb, b_busy); end
    @(negedge clk);
    checks++; if (b_busy !== 1'b0 || m_wmask !== 4'h0) begin errors++; $display("FAIL wr_c2: got busy %b mask %b expected 0/0000", b_busy, m_wmask); end
    b_addr = 32'h20; b_rstrb = 1'b1;
    @(negedge clk); idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (b_busy !== 1'b0 || b_rdata !== 32'h1122_AA44) begin errors++; $display("FAIL wr_readback: got busy %b data %h expected 0/1122aa44", b_busy, b_rdata); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL wr_a_rdata_held: got %h expected 0", a_rdata); end
  endtask

  task automatic test_tie;
    do_reset();
    a_addr = 32'h0; a_rstrb = 1'b1; b_addr = 32'h4; b_rstrb = 1'b1;
    @(negedge clk); idle_inputs();
    checks++; if (m_rstrb !== 1'b1 || m_addr !== 32'h0) begin errors++; $display("FAIL tie_c1_a: got rstrb %b addr %h expected 1/00000000", m_rstrb, m_addr); end
    repeat (2) @(negedge clk);
    checks++; if (m_rstrb !== 1'b1 || m_addr !== 32'h4) begin errors++; $display("FAIL tie_c3_b: got rstrb %b addr %h expected 1/00000004", m_rstrb, m_addr); end
    checks++; if (a_busy !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL tie_c3_busy: got %b/%b expected 0/1", a_busy, b_busy); end
    checks++; if (a_rdata !== 32'hA0A0_A0A0) begin errors++; $display("FAIL tie_a_rdata: got %h expected a0a0a0a0", a_rdata); end
    @(negedge clk);
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL tie_c4_b_busy: got %b expected 1", b_busy); end
    @(negedge clk);
    checks++; if (b_busy !== 1'b0 || b_rdata !== 32'hB1B1_B1B1) begin errors++; $display("FAIL tie_c5_b: got busy %b data %h expected 0/b1b1b1b1", b_busy, b_rdata); end
  endtask

  task automatic test_sustained;
    int          a_left, b_left;
    logic [31:0] exp_addr;
    do_reset();
    issue_log.delete();
    a_left = 4; b_left = 4;
    for (int cyc = 0; cyc < 80 && issue_log.size() < 8; cyc++) begin
      a_addr = 32'h40; a_rstrb = (!a_busy && a_left > 0);
      b_addr = 32'h80; b_rstrb = (!b_busy && b_left > 0);
      if (a_rstrb) a_left--;
      if (b_rstrb) b_left--;
      @(negedge clk);
    end
    idle_inputs();
    repeat (4) @(negedge clk);
    checks++; if (issue_log.size() != 8) begin errors++; $display("FAIL rr_issue_count: got %0d expected 8", issue_log.size()); end
    for (int i = 0; i < 8; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h40 : 32'h80;
      checks++;
      if (i >= issue_log.size()) begin errors++; $display("FAIL rr_order[%0d]: got none expected %h", i, exp_addr); end
      else if (issue_log[i] !== exp_addr) begin errors++; $display("FAIL rr_order[%0d]: got %h expected %h", i, issue_log[i], exp_addr); end
    end
    checks++; if (a_rdata !== 32'h4040_4040 || b_rdata !== 32'h8080_8080) begin errors++; $display("FAIL rr_rdata: got %h/%h expected 40404040/80808080", a_rdata, b_rdata); end
  endtask

  task automatic test_fixed_priority;
    do_reset();
    a_addr = 32'h0; a_rstrb = 1'b1;
    @(negedge clk); idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (a_busy !== 1'b0 || f_a_busy !== 1'b0) begin errors++; $display("FAIL fp_c3_idle: got %b/%b expected 0/0", a_busy, f_a_busy); end
    a_addr = 32'h0; a_rstrb = 1'b1; b_addr = 32'h4; b_rstrb = 1'b1;
    @(negedge clk); idle_inputs();
    checks++; if (m_rstrb !== 1'b1 || m_addr !== 32'h4) begin errors++; $display("FAIL rr_tie_after_a: got rstrb %b addr %h expected 1/00000004", m_rstrb, m_addr); end
    checks++; if (f_m_rstrb !== 1'b1 || f_m_addr !== 32'h0) begin errors++; $display("FAIL fp_tie_a_wins: got rstrb %b addr %h expected 1/00000000", f_m_rstrb, f_m_addr); end
    repeat (2) @(negedge clk);
    checks++; if (m_rstrb !== 1'b1 || m_addr !== 32'h0) begin errors++; $display("FAIL rr_second: got rstrb %b addr %h expected 1/00000000", m_rstrb, m_addr); end
    checks++; if (f_m_rstrb !== 1'b1 || f_m_addr !== 32'h4 || f_b_busy !== 1'b1) begin errors++; $display("FAIL fp_second: got rstrb %b addr %h busy %b expected 1/00000004/1", f_m_rstrb, f_m_addr, f_b_busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    a_addr = 32'h0; a_rstrb = 1'b1;
    @(negedge clk); idle_inputs();
    b_addr = 32'h30; b_wdata = 32'hFFFF_FFFF; b_wmask = 4'hF;
    @(negedge clk); idle_inputs();
    checks++; if (b_busy !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL mid_c2_busy: got %b/%b expected 1/1", a_busy, b_busy); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL mid_c3_busy: got %b/%b expected 0/0", a_busy, b_busy); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL mid_c3_rdata: got %h expected 0", a_rdata); end
    repeat (3) @(negedge clk);
    checks++; if (mem[12] !== 32'h5566_7788) begin errors++; $display("FAIL mid_ram_unchanged: got %h expected 55667788", mem[12]); end
  endtask

  task automatic test_busy_violation;
    int viol0, rd0;
    do_reset();
    viol0 = viol; rd0 = rd_issues;
    a_addr = 32'h10; a_rstrb = 1'b1;
    @(negedge clk);
    a_addr = 32'h14; a_rstrb = 1'b1;
    @(negedge clk); idle_inputs();
    repeat (5) @(negedge clk);
    checks++; if (rd_issues - rd0 != 1) begin errors++; $display("FAIL viol_one_issue: got %0d expected 1", rd_issues - rd0); end
    checks++; if (viol - viol0 != 1) begin errors++; $display("FAIL viol_flagged: got %0d expected 1", viol - viol0); end
    checks++; if (a_rdata !== 32'hDEAD_BEEF || a_busy !== 1'b0) begin errors++; $display("FAIL viol_rdata: got %h busy %b expected deadbeef/0", a_rdata, a_busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'hA0A0_A0A0;
    mem[1]  = 32'hB1B1_B1B1;
    mem[4]  = 32'hDEAD_BEEF;
    mem[5]  = 32'h0BAD_F00D;
    mem[8]  = 32'h1122_3344;
    mem[12] = 32'h5566_7788;
    mem[13] = 32'h1234_5678;
    mem[16] = 32'h4040_4040;
    mem[32] = 32'h8080_8080;
    idle_inputs();
    test_reset();
    test_single_read();
    test_byte_write();
    test_tie();
    test_sustained();
    test_fixed_priority();
    test_reset_mid_read();
    test_busy_violation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
